// File: rtl/xgmii_to_axis_if.sv
// AXI-Stream beat bus carrying decoded XGMII receive frames toward the MAC.
interface xgmii_to_axis_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tuser;

   modport master (output tdata, tvalid, tkeep, tlast, tuser);
   modport slave  (input  tdata, tvalid, tkeep, tlast, tuser);
endinterface

// File: rtl/xgmii_to_axis.sv
// 64-bit XGMII receive decoder: strips Start, realigns frame bytes into AXI-Stream beats.
// Define XGMII_LANE4_START_EN to also accept a Start character in lane 4.
module xgmii_to_axis #(
   parameter bit CHECK_PREAMBLE = 1'b0
) (
   input  logic            clock,
   input  logic            aresetn,
   input  logic [63:0]     xgmii_d,
   input  logic [7:0]      xgmii_c,
   xgmii_to_axis_if.master maxis
);
   localparam logic [7:0]  START    = 8'hFB;
   localparam logic [7:0]  TERM     = 8'hFD;
   localparam logic [55:0] PREAMBLE = 56'hD5_55_55_55_55_55_55;

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
   state_t state, state_nxt;

   logic [63:0] cur_d, prev_d;
   logic [7:0]  cur_c, prev_c;
   logic [2:0]  shift, shift_nxt;
   logic        first, first_nxt;
   logic        pre_err, pre_err_nxt;
   logic [7:0]  tail_keep, tail_keep_nxt;
   logic        tail_user, tail_user_nxt;
   logic [63:0] tdata_nxt;
   logic [7:0]  tkeep_nxt;
   logic        tvalid_nxt, tlast_nxt, tuser_nxt;

   logic [63:0] beat_d;
   logic [6:0]  beat_c;
   logic        start0, start4;
   logic [2:0]  start_shift;
   logic [3:0]  data_end, start_end, last_count;
   logic [2:0]  data_t;
   logic        pre_bad, pre_flag, data_bad, start_bad;

   function automatic logic [3:0] first_ctrl(input logic [7:0] c);
      first_ctrl = 4'b1000;
      for (int i = 7; i >= 0; i--)
         if (c[i]) first_ctrl = 4'(i);
   endfunction

   function automatic logic [7:0] keep_of(input logic [3:0] n);
      return 8'((9'h1 << n) - 9'h1);
   endfunction

   function automatic logic [63:0] byte_mask(input logic [7:0] k);
      for (int i = 0; i < 8; i++)
         byte_mask[8*i +: 8] = {8{k[i]}};
   endfunction

   // shift is the lane right after Start; a beat is always the word pair realigned by it.
   assign beat_d = 64'({cur_d, prev_d} >> {shift, 3'b000});
   assign beat_c = 7'({cur_c, prev_c} >> shift);

   assign start0 = cur_c[0] && (cur_d[7:0] == START);
`ifdef XGMII_LANE4_START_EN
   assign start4 = !start0 && cur_c[4] && (cur_d[39:32] == START);
`else
   assign start4 = 1'b0;
`endif
   assign start_shift = start4 ? 3'd5 : 3'd1;

   assign data_end   = first_ctrl(cur_c);
   assign data_t     = data_end[2:0];
   assign data_bad   = cur_d[{data_t, 3'b000} +: 8] != TERM;
   assign start_end  = first_ctrl(cur_c & ~keep_of({1'b0, start_shift}));
   assign start_bad  = cur_d[{start_end[2:0], 3'b000} +: 8] != TERM;
   assign last_count = 4'd8 - {1'b0, shift} + {1'b0, data_t};
   assign pre_bad    = CHECK_PREAMBLE && ((beat_d[55:0] != PREAMBLE) || (beat_c != 7'd0));
   assign pre_flag   = first ? pre_bad : pre_err;

   // A beat is only released once the following word proves whether it is the last,
   // so a terminator can never find an already-sent beat lacking its tlast.
   always_comb begin
      state_nxt     = state;
      shift_nxt     = shift;
      first_nxt     = 1'b0;
      pre_err_nxt   = pre_err;
      tail_keep_nxt = tail_keep;
      tail_user_nxt = tail_user;
      tdata_nxt     = '0;
      tkeep_nxt     = '0;
      tvalid_nxt    = 1'b0;
      tlast_nxt     = 1'b0;
      tuser_nxt     = 1'b0;
      case (state)
         DATA: begin
            tvalid_nxt = 1'b1;
            tkeep_nxt  = 8'hFF;
            if (data_end[3]) begin
               pre_err_nxt = pre_flag;
            end else if (data_t <= shift) begin
               tkeep_nxt = keep_of(last_count);
               tlast_nxt = 1'b1;
               tuser_nxt = data_bad | pre_flag;
               state_nxt = IDLE;
            end else begin
               tail_keep_nxt = keep_of({1'b0, 3'(data_t - shift)});
               tail_user_nxt = data_bad | pre_flag;
               state_nxt     = TAIL;
            end
            tdata_nxt = beat_d & byte_mask(tkeep_nxt);
         end
         default: begin
            if (state == TAIL) begin
               tvalid_nxt = 1'b1;
               tlast_nxt  = 1'b1;
               tkeep_nxt  = tail_keep;
               tuser_nxt  = tail_user;
               tdata_nxt  = beat_d & byte_mask(tail_keep);
            end
            state_nxt = IDLE;
            // A frame ending inside its Start word is shorter than the preamble.
            if (start0 || start4) begin
               shift_nxt = start_shift;
               if (start_end[3]) begin
                  state_nxt = DATA;
                  first_nxt = 1'b1;
               end else if (start_end[2:0] > start_shift) begin
                  tail_keep_nxt = keep_of({1'b0, 3'(start_end[2:0] - start_shift)});
                  tail_user_nxt = start_bad | CHECK_PREAMBLE;
                  state_nxt     = TAIL;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         state        <= IDLE;
         cur_d        <= '0;
         cur_c        <= '0;
         prev_d       <= '0;
         prev_c       <= '0;
         shift        <= 3'd1;
         first        <= 1'b0;
         pre_err      <= 1'b0;
         tail_keep    <= '0;
         tail_user    <= 1'b0;
         maxis.tdata  <= '0;
         maxis.tkeep  <= '0;
         maxis.tvalid <= 1'b0;
         maxis.tlast  <= 1'b0;
         maxis.tuser  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_d        <= xgmii_d;
         cur_c        <= xgmii_c;
         prev_d       <= cur_d;
         prev_c       <= cur_c;
         shift        <= shift_nxt;
         first        <= first_nxt;
         pre_err      <= pre_err_nxt;
         tail_keep    <= tail_keep_nxt;
         tail_user    <= tail_user_nxt;
         maxis.tdata  <= tdata_nxt;
         maxis.tkeep  <= tkeep_nxt;
         maxis.tvalid <= tvalid_nxt;
         maxis.tlast  <= tlast_nxt;
         maxis.tuser  <= tuser_nxt;
      end
   end
endmodule

// File: tb/tb_xgmii_to_axis.sv
// Scoreboard bench for xgmii_to_axis: one DUT without and one with preamble checking, same stimulus.
module tb_xgmii_to_axis;
   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   logic        clock = 1'b0;
   logic        aresetn = 1'b1;
   logic [63:0] xgmii_d = {8{8'h07}};
   logic [7:0]  xgmii_c = 8'hFF;

   int    checks = 0;
   int    failures = 0;
   beat_t q0[$];
   beat_t q1[$];
   bit    in_frame [2];
   logic [7:0] fb [0:127];

   xgmii_to_axis_if ax0 ();
   xgmii_to_axis_if ax1 ();

   xgmii_to_axis #(.CHECK_PREAMBLE(1'b0)) dut0 (
      .clock(clock), .aresetn(aresetn), .xgmii_d(xgmii_d), .xgmii_c(xgmii_c), .maxis(ax0)
   );
   xgmii_to_axis #(.CHECK_PREAMBLE(1'b1)) dut1 (
      .clock(clock), .aresetn(aresetn), .xgmii_d(xgmii_d), .xgmii_c(xgmii_c), .maxis(ax1)
   );

   always #5 clock = ~clock;

   task automatic check_output(input int idx, input logic [63:0] d, input logic v,
                               input logic [7:0] k, input logic l, input logic u);
      beat_t e;
      logic [63:0] m;
      if (in_frame[idx]) begin
         checks++;
         if (!v) begin
            failures++;
            $display("[TB] FAIL gap dut%0d: tvalid=0 mid-frame, required 1", idx);
            in_frame[idx] = 1'b0;
         end
      end
      if (v) begin
         checks++;
         if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            failures++;
            $display("[TB] FAIL unexpected dut%0d: beat data=%h keep=%h last=%b, required none",
                     idx, d, k, l);
         end else begin
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{e.keep[i]}};
            if ((d & m) !== e.data || k !== e.keep || l !== e.last || u !== e.user) begin
               failures++;
               $display("[TB] FAIL beat dut%0d: got data=%h keep=%h last=%b user=%b, required data=%h keep=%h last=%b user=%b",
                        idx, d & m, k, l, u, e.data, e.keep, e.last, e.user);
            end
         end
         in_frame[idx] = !l;
      end
   endtask

   always @(negedge clock) begin
      if (aresetn) begin
         check_output(0, ax0.tdata, ax0.tvalid, ax0.tkeep, ax0.tlast, ax0.tuser);
         check_output(1, ax1.tdata, ax1.tvalid, ax1.tkeep, ax1.tlast, ax1.tuser);
      end
   end

   task automatic check_reset(input string name);
      checks++;
      if (ax0.tvalid !== 1'b0 || ax0.tlast !== 1'b0 || ax0.tuser !== 1'b0 ||
          ax0.tkeep !== 8'h00 || ax0.tdata !== 64'h0) begin
         failures++;
         $display("[TB] FAIL reset_%s dut0: got valid=%b last=%b user=%b keep=%h data=%h, required all 0",
                  name, ax0.tvalid, ax0.tlast, ax0.tuser, ax0.tkeep, ax0.tdata);
      end
      checks++;
      if (ax1.tvalid !== 1'b0 || ax1.tlast !== 1'b0 || ax1.tuser !== 1'b0 ||
          ax1.tkeep !== 8'h00 || ax1.tdata !== 64'h0) begin
         failures++;
         $display("[TB] FAIL reset_%s dut1: got valid=%b last=%b user=%b keep=%h data=%h, required all 0",
                  name, ax1.tvalid, ax1.tlast, ax1.tuser, ax1.tkeep, ax1.tdata);
      end
   endtask

   task automatic send_word(input logic [63:0] d, input logic [7:0] c);
      @(posedge clock);
      #1;
      xgmii_d = d;
      xgmii_c = c;
   endtask

   task automatic fill_frame(input bit pre, input logic [7:0] base);
      for (int i = 0; i < 128; i++) fb[i] = base + 8'(i);
      if (pre) begin
         for (int i = 0; i < 6; i++) fb[i] = 8'h55;
         fb[6] = 8'hD5;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clock);
      #3;
      aresetn = 1'b0;
      #1;
      check_reset("midframe");
      q0.delete();
      q1.delete();
      in_frame[0] = 1'b0;
      in_frame[1] = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      aresetn = 1'b1;
   endtask

   // Pushes the expected beats (unless the frame must be ignored), then drives the words.
   task automatic apply_stimulus(input int len, input bit lane4, input logic [7:0] end_code,
                                 input int gap, input bit ignored, input int abort_word);
      beat_t e;
      int s, endp, nwords, n, p;
      bit pre_ok;
      logic [63:0] d;
      logic [7:0] c;
      pre_ok = (len >= 7) && (fb[0] == 8'h55) && (fb[1] == 8'h55) && (fb[2] == 8'h55) &&
               (fb[3] == 8'h55) && (fb[4] == 8'h55) && (fb[5] == 8'h55) && (fb[6] == 8'hD5);
      if (!ignored) begin
         for (int b = 0; 8*b < len; b++) begin
            n = len - 8*b;
            if (n > 8) n = 8;
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < n; i++) begin
               e.data[8*i +: 8] = fb[8*b + i];
               e.keep[i] = 1'b1;
            end
            e.last = (8*b + 8 >= len);
            e.user = e.last && (end_code != 8'hFD);
            q0.push_back(e);
            e.user = e.last && ((end_code != 8'hFD) || !pre_ok);
            q1.push_back(e);
         end
      end
      s = lane4 ? 5 : 1;
      endp = s + len;
      nwords = endp / 8 + 1;
      for (int w = 0; w < nwords; w++) begin
         if (w == abort_word) pulse_reset();
         for (int l = 0; l < 8; l++) begin
            p = 8*w + l;
            if (p == s - 1) begin
               d[8*l +: 8] = 8'hFB;
               c[l] = 1'b1;
            end else if (p >= s && p < endp) begin
               d[8*l +: 8] = fb[p - s];
               c[l] = 1'b0;
            end else if (p == endp) begin
               d[8*l +: 8] = end_code;
               c[l] = 1'b1;
            end else begin
               d[8*l +: 8] = 8'h07;
               c[l] = 1'b1;
            end
         end
         send_word(d, c);
      end
      repeat (gap) send_word({8{8'h07}}, 8'hFF);
   endtask

   initial begin
      #2;
      aresetn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset("initial");
      @(negedge clock);
      aresetn = 1'b1;
      repeat (2) send_word({8{8'h07}}, 8'hFF);

      $display("[TB] 64-byte frame, FD lane 1");
      fill_frame(1'b0, 8'h00);
      apply_stimulus(64, 1'b0, 8'hFD, 2, 1'b0, -1);

      $display("[TB] 60-byte frame, TAIL, then Start in the very next word");
      fill_frame(1'b1, 8'h40);
      apply_stimulus(60, 1'b0, 8'hFD, 0, 1'b0, -1);

      $display("[TB] FE in lane 3 mid-frame, then clean frame after one idle");
      fill_frame(1'b1, 8'h80);
      apply_stimulus(34, 1'b0, 8'hFE, 1, 1'b0, -1);
      fill_frame(1'b1, 8'hA0);
      apply_stimulus(30, 1'b0, 8'hFD, 1, 1'b0, -1);

      $display("[TB] idle control in lane 6 mid-frame");
      fill_frame(1'b1, 8'hC0);
      apply_stimulus(29, 1'b0, 8'h07, 1, 1'b0, -1);

      $display("[TB] end in lane 0, zero-byte frame, short frame in Start word");
      fill_frame(1'b1, 8'h20);
      apply_stimulus(7, 1'b0, 8'hFD, 1, 1'b0, -1);
      apply_stimulus(0, 1'b0, 8'hFD, 0, 1'b0, -1);
      fill_frame(1'b0, 8'h31);
      apply_stimulus(3, 1'b0, 8'hFD, 0, 1'b0, -1);

      $display("[TB] preamble byte 3 = 0x54");
      fill_frame(1'b1, 8'h10);
      fb[3] = 8'h54;
      apply_stimulus(20, 1'b0, 8'hFD, 1, 1'b0, -1);

      $display("[TB] reset mid-frame, then a fresh frame");
      fill_frame(1'b0, 8'h60);
      apply_stimulus(40, 1'b0, 8'hFD, 2, 1'b0, 3);
      fill_frame(1'b1, 8'h70);
      apply_stimulus(16, 1'b0, 8'hFD, 1, 1'b0, -1);

      fill_frame(1'b1, 8'hE0);
`ifdef XGMII_LANE4_START_EN
      $display("[TB] Start in lane 4, 16-byte frame");
      apply_stimulus(16, 1'b1, 8'hFD, 1, 1'b0, -1);
`else
      $display("[TB] Start in lane 4 must be ignored");
      apply_stimulus(16, 1'b1, 8'hFD, 1, 1'b1, -1);
`endif
      fill_frame(1'b1, 8'hF0);
      apply_stimulus(13, 1'b0, 8'hFD, 1, 1'b0, -1);

      repeat (8) send_word({8{8'h07}}, 8'hFF);
      checks++;
      if (q0.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain dut0: %0d beats outstanding, required 0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain dut1: %0d beats outstanding, required 0", q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
